// File: rtl/eth_rx_cmd_parser.sv
// Command-frame parser for the 8-bit LocalLink RX stream of the Ethernet MAC.
// Filters on destination MAC and EtherType, then hands one command to control logic.
module eth_rx_cmd_parser #(
  parameter logic [47:0] MY_MAC    = 48'h000A35000001,
  parameter logic [15:0] CMD_ETYPE = 16'h88B5
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_sof_n,
  input  logic        rx_eof_n,
  input  logic        rx_src_rdy_n,
  output logic        rx_dst_rdy_n,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [31:0] cmd_data,
  input  logic        cmd_ack,
  output logic [7:0]  good_cnt,
  output logic [7:0]  bad_cnt,
  output logic [7:0]  drop_cnt
);

  localparam logic [4:0] LAST_HDR = 5'd13;
  localparam logic [4:0] LAST_PAY = 5'd19;
  localparam logic [4:0] MIN_LEN  = 5'd20;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx, idx;
  logic        ucast_miss, bcast_miss, etype_miss;
  logic        ucast_nx, bcast_nx, etype_nx;
  logic [7:0]  op_sh, addr_sh, op_nx, addr_nx, mac_byte;
  logic [31:0] data_sh, data_nx;
  logic        beat, sof_beat, active, in_hdr, in_pay;
  logic        eval, frame_good, abort, load, drop;
  logic [1:0]  bad_inc;

  // The MAC is never stalled; ready only drops while reset is held.
  assign rx_dst_rdy_n = rst;

  assign beat     = !rx_src_rdy_n && !rx_dst_rdy_n;
  assign sof_beat = beat && !rx_sof_n;
  assign active   = sof_beat || (beat && state != IDLE);
  assign idx      = sof_beat ? 5'd0 : cnt;
  assign in_hdr   = active && (sof_beat || state == HDR);
  assign in_pay   = active && !sof_beat && state == PAYLOAD;

  always_comb begin
    case (idx[2:0])
      3'd0:    mac_byte = MY_MAC[47:40];
      3'd1:    mac_byte = MY_MAC[39:32];
      3'd2:    mac_byte = MY_MAC[31:24];
      3'd3:    mac_byte = MY_MAC[23:16];
      3'd4:    mac_byte = MY_MAC[15:8];
      3'd5:    mac_byte = MY_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path holds an old value and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ucast_nx = sof_beat ? 1'b0 : ucast_miss;
    bcast_nx = sof_beat ? 1'b0 : bcast_miss;
    etype_nx = sof_beat ? 1'b0 : etype_miss;
    op_nx    = op_sh;
    addr_nx  = addr_sh;
    data_nx  = data_sh;

    // Unicast and broadcast are tracked separately so a mixed address is rejected.
    if (in_hdr) begin
      if (idx < 5'd6) begin
        ucast_nx = ucast_nx | (rx_data != mac_byte);
        bcast_nx = bcast_nx | (rx_data != 8'hFF);
      end
      if (idx == 5'd12) etype_nx = etype_nx | (rx_data != CMD_ETYPE[15:8]);
      if (idx == 5'd13) etype_nx = etype_nx | (rx_data != CMD_ETYPE[7:0]);
    end

    if (in_pay) begin
      if (idx == 5'd14)      op_nx   = rx_data;
      else if (idx == 5'd15) addr_nx = rx_data;
      else                   data_nx = {data_sh[23:0], rx_data};
    end

    if (active) begin
      if (sof_beat)            cnt_nx = 5'd1;
      else if (cnt != MIN_LEN) cnt_nx = cnt + 5'd1;

      if (!rx_eof_n)                                state_nx = IDLE;
      else if (sof_beat)                            state_nx = HDR;
      else if (state == HDR && idx == LAST_HDR)     state_nx = PAYLOAD;
      else if (state == PAYLOAD && idx == LAST_PAY) state_nx = DRAIN;
    end
  end

  // The eof byte itself counts, so a frame ending on byte 19 brings cnt_nx to 20.
  assign eval       = active && !rx_eof_n;
  assign frame_good = !(ucast_nx && bcast_nx) && !etype_nx && (cnt_nx == MIN_LEN);
  assign abort      = sof_beat && state != IDLE;
  assign load       = eval && frame_good && (!cmd_valid || cmd_ack);
  assign drop       = eval && frame_good && cmd_valid && !cmd_ack;
  assign bad_inc    = {1'b0, abort} + {1'b0, eval && !frame_good};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: shadow and command registers are reset as well, so cmd_* read as zero until the first command.
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ucast_miss <= 1'b0;
      bcast_miss <= 1'b0;
      etype_miss <= 1'b0;
      op_sh      <= '0;
      addr_sh    <= '0;
      data_sh    <= '0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      cnt        <= cnt_nx;
      ucast_miss <= ucast_nx;
      bcast_miss <= bcast_nx;
      etype_miss <= etype_nx;
      op_sh      <= op_nx;
      addr_sh    <= addr_nx;
      data_sh    <= data_nx;
      bad_cnt    <= bad_cnt + {6'd0, bad_inc};

      if (load) begin
        cmd_valid <= 1'b1;
        cmd_op    <= op_nx;
        cmd_addr  <= addr_nx;
        cmd_data  <= data_nx;
        good_cnt  <= good_cnt + 8'd1;
      end else if (cmd_ack) begin
        cmd_valid <= 1'b0;
      end

      if (drop) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_cmd_parser.sv
// Scoreboard bench for eth_rx_cmd_parser: directed frames push expected commands,
// a negedge monitor pops and compares each newly presented command.
`timescale 1ns/1ps
module tb_eth_rx_cmd_parser;

  localparam logic [47:0] MY  = 48'h000A35000001;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] ET  = 16'h88B5;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_sof_n = 1'b1, rx_eof_n = 1'b1, rx_src_rdy_n = 1'b1;
  logic        rx_dst_rdy_n;
  logic        cmd_valid;
  logic [7:0]  cmd_op, cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_ack = 1'b0;
  logic [7:0]  good_cnt, bad_cnt, drop_cnt;

  eth_rx_cmd_parser dut (
    .clk125MHz    (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_sof_n     (rx_sof_n),
    .rx_eof_n     (rx_eof_n),
    .rx_src_rdy_n (rx_src_rdy_n),
    .rx_dst_rdy_n (rx_dst_rdy_n),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_ack      (cmd_ack),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #4 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  cmd_t       sb[$];
  logic [7:0] frm [0:63];
  logic [7:0] eg = 8'd0, eb = 8'd0, ed = 8'd0;
  bit         gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a command is new when valid rises or the presented fields change.
  cmd_t cur, prev, exp_cmd;
  bit   prev_v = 1'b0;
  always @(negedge clk) begin
    cur = {cmd_op, cmd_addr, cmd_data};
    if (cmd_valid === 1'b1 && (!prev_v || cur != prev)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got op=%0h addr=%0h data=%0h expected none", cmd_op, cmd_addr, cmd_data);
      end else begin
        exp_cmd = sb.pop_front();
        check("cmd_op",   64'(cmd_op),   64'(exp_cmd.op));
        check("cmd_addr", 64'(cmd_addr), 64'(exp_cmd.addr));
        check("cmd_data", 64'(cmd_data), 64'(exp_cmd.data));
      end
    end
    prev_v = (cmd_valid === 1'b1);
    prev   = cur;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] op,
                       input logic [7:0] addr, input logic [31:0] data);
    logic [47:0] src;
    src = 48'h001122334455;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dst[47-8*i -: 8];
      frm[6 + i] = src[47-8*i -: 8];
    end
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    frm[14] = op;
    frm[15] = addr;
    for (int i = 0; i < 4; i++) frm[16 + i] = data[31-8*i -: 8];
    for (int i = 20; i < 64; i++) frm[i] = 8'(8'hA0 + i);
  endtask

  // Drives frm[first..last]; the final byte is left on the bus for the next edge to consume.
  task automatic send(input int first, input int last, input bit sof, input bit eof, input bit ack_eof);
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        rx_src_rdy_n = 1'b1;
        rx_sof_n     = ($urandom_range(0, 1) == 0);
        rx_eof_n     = ($urandom_range(0, 1) == 0);
        rx_data      = 8'($urandom_range(0, 255));
        cmd_ack      = 1'b0;
      end
      @(negedge clk);
      rx_src_rdy_n = 1'b0;
      rx_data      = frm[i];
      rx_sof_n     = !(sof && i == first);
      rx_eof_n     = !(eof && i == last);
      cmd_ack      = ack_eof && eof && i == last;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_src_rdy_n = 1'b1;
    rx_sof_n     = 1'b1;
    rx_eof_n     = 1'b1;
    cmd_ack      = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check("ack_clears_valid", 64'(cmd_valid), 64'd0);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'(eg));
    check({tag, "_bad_cnt"},  64'(bad_cnt),  64'(eb));
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(ed));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dst_rdy_n"}, 64'(rx_dst_rdy_n), 64'd1);
    check({tag, "_cmd_valid"}, 64'(cmd_valid),    64'd0);
    check({tag, "_cmd_op"},    64'(cmd_op),       64'd0);
    check({tag, "_cmd_addr"},  64'(cmd_addr),     64'd0);
    check({tag, "_cmd_data"},  64'(cmd_data),     64'd0);
    check_cnts(tag);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(rx_dst_rdy_n), 64'd0);

    // Good 64-byte frame
    build(MY, ET, 8'h01, 8'h10, 32'hDEADBEEF);
    sb.push_back({8'h01, 8'h10, 32'hDEADBEEF});
    send(0, 63, 1, 1, 0);
    idle();
    eg++;
    check("good_valid", 64'(cmd_valid), 64'd1);
    check_cnts("good");
    ack();

    // Broadcast accepted
    build(BC, ET, 8'h02, 8'h20, 32'h01020304);
    sb.push_back({8'h02, 8'h20, 32'h01020304});
    send(0, 59, 1, 1, 0);
    idle();
    eg++;
    check("bcast_valid", 64'(cmd_valid), 64'd1);
    check_cnts("bcast");
    ack();

    // Destination mismatch, then wrong EtherType
    build(48'h000A35000002, ET, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    send(0, 63, 1, 1, 0);
    idle();
    eb++;
    check("dst_bad_valid", 64'(cmd_valid), 64'd0);
    check_cnts("dst_bad");
    build(MY, 16'h0800, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    send(0, 63, 1, 1, 0);
    idle();
    eb++;
    check_cnts("etype_bad");

    // Length boundaries: 19 bad, 20 good, single byte bad
    build(MY, ET, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    send(0, 18, 1, 1, 0);
    idle();
    eb++;
    check("len19_valid", 64'(cmd_valid), 64'd0);
    check_cnts("len19");
    build(MY, ET, 8'h03, 8'h30, 32'h11223344);
    sb.push_back({8'h03, 8'h30, 32'h11223344});
    send(0, 19, 1, 1, 0);
    idle();
    eg++;
    check_cnts("len20");
    ack();
    send(0, 0, 1, 1, 0);
    idle();
    eb++;
    check_cnts("len1");

    // Overflow: back-to-back good frames without ack keep the first command
    build(MY, ET, 8'h04, 8'h40, 32'hA0A0A0A0);
    sb.push_back({8'h04, 8'h40, 32'hA0A0A0A0});
    send(0, 63, 1, 1, 0);
    build(MY, ET, 8'h05, 8'h50, 32'hB0B0B0B0);
    send(0, 63, 1, 1, 0);
    idle();
    eg++;
    ed++;
    check("ovf_kept_op", 64'(cmd_op), 64'h04);
    check_cnts("ovf");
    ack();

    // Ack on the second eof cycle lets the new command replace the old one
    build(MY, ET, 8'h06, 8'h60, 32'hC0C0C0C0);
    sb.push_back({8'h06, 8'h60, 32'hC0C0C0C0});
    send(0, 63, 1, 1, 0);
    build(MY, ET, 8'h07, 8'h70, 32'hD0D0D0D0);
    sb.push_back({8'h07, 8'h70, 32'hD0D0D0D0});
    send(0, 63, 1, 1, 1);
    idle();
    eg += 8'd2;
    check("ovf_ack_valid", 64'(cmd_valid), 64'd1);
    check("ovf_ack_op", 64'(cmd_op), 64'h07);
    check_cnts("ovf_ack");
    ack();

    // sof at byte 9 aborts the first frame
    build(MY, ET, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    send(0, 8, 1, 0, 0);
    build(MY, ET, 8'h08, 8'h80, 32'h12345678);
    sb.push_back({8'h08, 8'h80, 32'h12345678});
    send(0, 63, 1, 1, 0);
    idle();
    eb++;
    eg++;
    check_cnts("abort");
    ack();

    // Reset at byte 15 with a command pending
    build(MY, ET, 8'h09, 8'h90, 32'hCAFEF00D);
    sb.push_back({8'h09, 8'h90, 32'hCAFEF00D});
    send(0, 63, 1, 1, 0);
    idle();
    eg++;
    check("pending_before_rst", 64'(cmd_valid), 64'd1);
    build(MY, ET, 8'h0A, 8'hA0, 32'h55AA55AA);
    send(0, 14, 1, 0, 0);
    @(negedge clk);
    rx_src_rdy_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    eg = 8'd0;
    eb = 8'd0;
    ed = 8'd0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    send(15, 63, 0, 1, 0);
    idle();
    check("post_rst_tail_valid", 64'(cmd_valid), 64'd0);
    check_cnts("post_rst_tail");
    build(MY, ET, 8'h0B, 8'hB0, 32'h87654321);
    sb.push_back({8'h0B, 8'hB0, 32'h87654321});
    send(0, 63, 1, 1, 0);
    idle();
    eg++;
    check_cnts("post_rst_good");
    ack();

    // bad_cnt wrap
    build(MY, 16'h0800, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    for (int n = 0; n < 255; n++) begin
      send(0, 1, 1, 1, 0);
      eb++;
    end
    idle();
    check("bad_cnt_255", 64'(bad_cnt), 64'(eb));
    send(0, 1, 1, 1, 0);
    idle();
    eb++;
    check("bad_cnt_wrap", 64'(bad_cnt), 64'd0);
    check_cnts("wrap");

    // Same scenarios with random idle gaps inside frames
    gaps = 1'b1;
    build(MY, ET, 8'h0C, 8'hC0, 32'hDEADBEEF);
    sb.push_back({8'h0C, 8'hC0, 32'hDEADBEEF});
    send(0, 63, 1, 1, 0);
    idle();
    eg++;
    check_cnts("gap_good");
    build(48'h000A35000002, ET, 8'hEE, 8'hEE, 32'hEEEEEEEE);
    send(0, 63, 1, 1, 0);
    idle();
    eb++;
    check_cnts("gap_bad");
    build(MY, ET, 8'h0D, 8'hD0, 32'h0BADF00D);
    send(0, 63, 1, 1, 0);
    idle();
    ed++;
    check("gap_kept_op", 64'(cmd_op), 64'h0C);
    check_cnts("gap_drop");
    ack();
    build(MY, ET, 8'h0E, 8'hE0, 32'h13579BDF);
    sb.push_back({8'h0E, 8'hE0, 32'h13579BDF});
    send(0, 19, 1, 1, 0);
    idle();
    eg++;
    check_cnts("gap_len20");
    ack();
    gaps = 1'b0;

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_cmd_parser.md
# eth_rx_cmd_parser

Receive-side frame parser for the Ethernet link of the SPAD acquisition board. Sits on the 8-bit LocalLink RX output of `eth_example_design`, in the `clk125MHz` domain. It accepts command frames sent by the host PC, checks the destination MAC and EtherType, and extracts one command (opcode, address, 32-bit data). The command is presented to the control logic through a valid/ack handshake. Good, bad and dropped frame counts are kept for diagnostics.

## Interface
Parameters:
- `MY_MAC`, 48'h000A35000001: board MAC address; broadcast 48'hFFFFFFFFFFFF is also accepted.
- `CMD_ETYPE`, 16'h88B5: EtherType of command frames.

Ports:
- `clk125MHz` input 1: Ethernet user clock; sole clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rx_data` input 8: RX byte.
- `rx_sof_n` input 1: start of frame, active-low.
- `rx_eof_n` input 1: end of frame, active-low.
- `rx_src_rdy_n` input 1: source ready, active-low.
- `rx_dst_rdy_n` output 1: destination ready, active-low.
- `cmd_valid` output 1: command available.
- `cmd_op` output 8: opcode.
- `cmd_addr` output 8: register address.
- `cmd_data` output 32: command data, big-endian on the wire.
- `cmd_ack` input 1: consumer takes the command.
- `good_cnt` output 8: good command frames accepted; wraps.
- `bad_cnt` output 8: frames rejected; wraps.
- `drop_cnt` output 8: good frames lost because a command was pending; wraps.

## Operation
- **Beat:** a byte is consumed on a rising edge when `rx_src_rdy_n`=0 and `rx_dst_rdy_n`=0.
- **Ready:** `rx_dst_rdy_n` is 1 during reset and 0 at all other times. The parser never stalls the MAC.
- **Frame layout (byte index):**
  - 0-5: destination MAC.
  - 6-11: source MAC (ignored).
  - 12-13: EtherType, MSB first.
  - 14: opcode.
  - 15: address.
  - 16-19: data, MSB first.
  - 20 onward: padding/FCS, ignored.
- **States:**
  - IDLE: wait for a beat with `rx_sof_n`=0. That beat is byte 0 and moves the FSM to HDR.
  - HDR (bytes 0-13): compare each byte against `MY_MAC`/broadcast and `CMD_ETYPE`. Any mismatch sets a sticky `err` flag; the frame continues to be consumed.
  - PAYLOAD (bytes 14-19): load shadow registers for op, addr and data.
  - DRAIN (byte 20 onward): discard bytes until the eof beat.
  - Any state: an eof beat returns the FSM to IDLE and evaluates the frame.
- **Byte counter:** 5 bits, reset to 0 on the sof beat, increments on each beat, saturates at 20.
- **Frame evaluation on the eof beat:**
  - Good = `err`=0 and byte count ≥ 20 (the eof byte counted).
  - Bad → `bad_cnt`+1.
  - Good and `cmd_valid`=0 → copy shadow registers to `cmd_*`, `good_cnt`+1.
  - Good and `cmd_valid`=1 → the pending command is kept unchanged and `drop_cnt`+1.
  - Exception: if `cmd_ack`=1 in that same cycle, the new command replaces the old one and counts as good, not dropped.
- **Protocol errors:**
  - sof beat while not in IDLE: the current frame is counted bad; that beat starts a new frame as byte 0.
  - Single-byte frame (sof and eof on the same beat): counted bad.
  - A beat without sof while in IDLE is ignored.
- **Handshake:** `cmd_valid` stays high until a cycle with `cmd_ack`=1. It clears on the edge after that cycle. `cmd_ack` while `cmd_valid`=0 has no effect.
- **Arithmetic:** all counters are 8-bit modulo-256 (255+1 → 0).

## Timing
- **Reset values:**
  - `rx_dst_rdy_n`=1, `cmd_valid`=0.
  - `cmd_op`, `cmd_addr`, `cmd_data`=0.
  - All counters 0; FSM in IDLE; `err`=0.
- **Reset mid-frame:** the partial frame is discarded without being counted. The parser resumes in IDLE and ignores bytes until the next sof.
- **Latency:** `cmd_valid` and the `cmd_*` fields update on the same edge that consumes the eof beat, so they are visible in the following cycle. The counters update on that same edge.
- **Throughput:** back-to-back frames are supported, with the eof of one frame on beat N and the sof of the next on beat N+1. Idle cycles (`rx_src_rdy_n`=1) may appear anywhere inside a frame.

## Test plan
- **Good frame:** 64-byte frame, dst=`MY_MAC`, etype 88B5, op 8'h01, addr 8'h10, data 32'hDEADBEEF. Expect `cmd_valid`=1 one cycle after eof with op=01, addr=10, data=DEADBEEF, and `good_cnt`=1. `cmd_ack` pulse → `cmd_valid`=0 on the next cycle.
- **Filtering:**
  - Broadcast destination → accepted.
  - dst byte 5 = 8'h02 → `bad_cnt`=1, no `cmd_valid`.
  - etype 0800 → `bad_cnt`=2.
- **Length:** 19-byte frame → bad. 20-byte frame → good. Single-byte sof+eof → bad.
- **Overflow:**
  - Two good frames with no ack → the first command is retained and `drop_cnt`=1.
  - Repeat with `cmd_ack` asserted on the second frame's eof cycle → the second command is loaded and `drop_cnt` is unchanged.
- **Interruption:**
  - sof at byte 9 → first frame counted bad, second frame parsed correctly.
  - `rst` pulse at byte 15 → all outputs return to reset values; the following good frame is accepted.
- **Wrap and stalls:** 256 bad frames → `bad_cnt` wraps to 0. Random `rx_src_rdy_n` gaps inside frames → results identical to the gap-free run.
